// File: rtl/res_ttl_test_sched.sv
// Round-robin TTL response sequencer: per enabled channel, drive a test square wave, count
// returned falling edges over a clk_1Mz-timed gate and latch pass/fail.
// Optional crosstalk check: define RES_TTL_CROSSTALK_CHK_EN.
`timescale 1ns/1ps
module res_ttl_test_sched #(
  parameter int unsigned N_CH         = 8,
  parameter int unsigned ETALON       = 50,
  parameter int unsigned TOL          = 3,
  parameter int unsigned HALF_PER     = 100,
  parameter int unsigned GATE_TICKS   = 100,
  parameter int unsigned SETTLE_TICKS = 2
) (
  input  logic            clk_100Mz,
  input  logic            rst_n,
  input  logic            clk_1Mz,
  input  logic            start,
  input  logic            abort,
  input  logic [N_CH-1:0] chan_mask,
  input  logic [N_CH-1:0] res_ttl_in,
  output logic [N_CH-1:0] res_ttl_out,
  output logic [N_CH-1:0] active_channel_res_ttl,
  output logic [N_CH-1:0] fail_mask,
`ifdef RES_TTL_CROSSTALK_CHK_EN
  output logic [N_CH-1:0] crosstalk_err,
`endif
  output logic            busy,
  output logic            done,
  output logic [2:0]      cur_ch,
  output logic [7:0]      last_cnt
);

  localparam int unsigned HP_W   = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int unsigned TK_MAX = (GATE_TICKS > SETTLE_TICKS) ? GATE_TICKS : SETTLE_TICKS;
  localparam int unsigned TK_W   = (TK_MAX > 1) ? $clog2(TK_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_MEASURE, S_JUDGE, S_NEXT, S_DONE
  } state_t;

  state_t          state;
  logic [2:0]      ch;
  logic [N_CH-1:0] mask;
  logic [HP_W-1:0] half_cnt;
  logic [TK_W-1:0] tick_cnt;
  logic [7:0]      cnt;
  logic [2:0]      clk_sh;
  logic [N_CH-1:0] in_s1, in_s2, in_prev;

  logic            tick_c;
  logic [N_CH-1:0] fall_c;
  logic            edge_c;
  logic            in_win_c;
  logic            wave_flip_c;

  // Synchronised edge detectors: {prev,cur} = {flop3,flop2}
  assign tick_c      = (clk_sh[2:1] == 2'b01);
  assign fall_c      = in_prev & ~in_s2;
  assign edge_c      = fall_c[ch];
  assign in_win_c    = (cnt > 8'(ETALON - TOL)) && (cnt < 8'(ETALON + TOL));
  assign wave_flip_c = (half_cnt == HP_W'(HALF_PER - 1));
  assign cur_ch      = ch;

`ifdef RES_TTL_CROSSTALK_CHK_EN
  logic            xt;
  logic [N_CH-1:0] sel_c;
  assign sel_c = N_CH'(1) << ch;
`endif

  always_ff @(posedge clk_100Mz or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= S_IDLE;
      ch                     <= '0;
      mask                   <= '0;
      half_cnt               <= '0;
      tick_cnt               <= '0;
      cnt                    <= '0;
      clk_sh                 <= '0;
      in_s1                  <= '0;
      in_s2                  <= '0;
      in_prev                <= '0;
      res_ttl_out            <= '0;
      active_channel_res_ttl <= '0;
      fail_mask              <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      last_cnt               <= '0;
`ifdef RES_TTL_CROSSTALK_CHK_EN
      xt                     <= 1'b0;
      crosstalk_err          <= '0;
`endif
    end else begin
      clk_sh  <= {clk_sh[1:0], clk_1Mz};
      in_s1   <= res_ttl_in;
      in_s2   <= in_s1;
      in_prev <= in_s2;
      done    <= 1'b0;

      if (abort && state != S_IDLE) begin
        // Abort keeps judged flags; no done pulse
        state       <= S_IDLE;
        busy        <= 1'b0;
        res_ttl_out <= '0;
      end else begin
        // Test wave runs continuously through settle and gate
        if (state == S_SETTLE || state == S_MEASURE) begin
          if (wave_flip_c) begin
            half_cnt        <= '0;
            res_ttl_out[ch] <= ~res_ttl_out[ch];
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end

        case (state)
          S_IDLE: begin
            if (start) begin
              mask                   <= chan_mask;
              active_channel_res_ttl <= '0;
              fail_mask              <= '0;
              last_cnt               <= '0;
`ifdef RES_TTL_CROSSTALK_CHK_EN
              crosstalk_err          <= '0;
`endif
              busy                   <= 1'b1;
              ch                     <= '0;
              state                  <= S_SELECT;
            end
          end
          S_SELECT: begin
            half_cnt    <= '0;
            tick_cnt    <= '0;
            res_ttl_out <= '0;
`ifdef RES_TTL_CROSSTALK_CHK_EN
            xt          <= 1'b0;
`endif
            state       <= mask[ch] ? S_SETTLE : S_NEXT;
          end
          S_SETTLE: begin
            if (tick_c) begin
              if (tick_cnt == TK_W'(SETTLE_TICKS - 1)) begin
                tick_cnt <= '0;
                cnt      <= '0;
                state    <= S_MEASURE;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          S_MEASURE: begin
            // Edge on the closing tick cycle is still counted
            if (edge_c && cnt != 8'hFF) cnt <= cnt + 8'd1;
`ifdef RES_TTL_CROSSTALK_CHK_EN
            if ((fall_c & ~sel_c) != '0) xt <= 1'b1;
`endif
            if (tick_c) begin
              if (tick_cnt == TK_W'(GATE_TICKS - 1)) begin
                tick_cnt <= '0;
                state    <= S_JUDGE;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          S_JUDGE: begin
            last_cnt    <= cnt;
            res_ttl_out <= '0;
`ifdef RES_TTL_CROSSTALK_CHK_EN
            if (in_win_c && !xt) active_channel_res_ttl[ch] <= 1'b1;
            else                 fail_mask[ch]              <= 1'b1;
            if (xt) crosstalk_err[ch] <= 1'b1;
`else
            if (in_win_c) active_channel_res_ttl[ch] <= 1'b1;
            else          fail_mask[ch]              <= 1'b1;
`endif
            state <= S_NEXT;
          end
          S_NEXT: begin
            if (ch == 3'(N_CH - 1)) begin
              state <= S_DONE;
            end else begin
              ch    <= ch + 1'b1;
              state <= S_SELECT;
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_res_ttl_test_sched.sv
// Randomized bench for res_ttl_test_sched with a per-channel expected-count model.
// Timebase scaled down: 4-cycle test wave, 8-cycle tick, 25-tick gate (200 cycles, 50 edges).
`timescale 1ns/1ps
module tb_res_ttl_test_sched;

  localparam int unsigned N_CH         = 8;
  localparam int unsigned ETALON       = 50;
  localparam int unsigned TOL          = 3;
  localparam int unsigned HALF_PER     = 2;
  localparam int unsigned GATE_TICKS   = 25;
  localparam int unsigned SETTLE_TICKS = 2;
  localparam int unsigned TICK_CYC     = 8;
  localparam int unsigned WIN_CYC      = GATE_TICKS * TICK_CYC;
  localparam int unsigned LOOP_CNT     = WIN_CYC / (2 * HALF_PER);
  localparam int          BUDGET       = 4000;

  logic       clk_100Mz = 1'b0;
  logic       clk_1Mz   = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic       abort     = 1'b0;
  logic [7:0] chan_mask = '0;
  logic [7:0] res_ttl_in;
  logic [7:0] res_ttl_out;
  logic [7:0] active;
  logic [7:0] fail_mask;
  logic       busy;
  logic       done;
  logic [2:0] cur_ch;
  logic [7:0] last_cnt;
`ifdef RES_TTL_CROSSTALK_CHK_EN
  logic [7:0] crosstalk_err;
`endif

  // Return-path environment
  logic [7:0] stuck      = '0;
  logic       rate_mode  = 1'b0;
  int         rate       = 50;
  logic       gen_bit    = 1'b0;
  int         gt         = 0;
  logic       short_mode = 1'b0;
  logic [7:0] lb;

  int passed = 0;
  int total  = 0;

  res_ttl_test_sched #(
    .N_CH(N_CH), .ETALON(ETALON), .TOL(TOL), .HALF_PER(HALF_PER),
    .GATE_TICKS(GATE_TICKS), .SETTLE_TICKS(SETTLE_TICKS)
  ) dut (
    .clk_100Mz              (clk_100Mz),
    .rst_n                  (rst_n),
    .clk_1Mz                (clk_1Mz),
    .start                  (start),
    .abort                  (abort),
    .chan_mask              (chan_mask),
    .res_ttl_in             (res_ttl_in),
    .res_ttl_out            (res_ttl_out),
    .active_channel_res_ttl (active),
    .fail_mask              (fail_mask),
`ifdef RES_TTL_CROSSTALK_CHK_EN
    .crosstalk_err          (crosstalk_err),
`endif
    .busy                   (busy),
    .done                   (done),
    .cur_ch                 (cur_ch),
    .last_cnt               (last_cnt)
  );

  initial forever #5 clk_100Mz = ~clk_100Mz;
  initial begin
    #3;
    forever #40 clk_1Mz = ~clk_1Mz;
  end

  // Square wave of exactly `rate` falling edges per WIN_CYC cycles, any alignment
  initial forever begin
    @(negedge clk_100Mz);
    gt      = (gt + 1) % int'(WIN_CYC);
    gen_bit = ((gt * rate) % int'(WIN_CYC)) < int'(WIN_CYC / 2);
  end

  always_comb begin
    lb = res_ttl_out;
    if (rate_mode) lb[0] = gen_bit;
`ifdef RES_TTL_CROSSTALK_CHK_EN
    if (short_mode) lb[5] = res_ttl_out[5] | res_ttl_out[2];
`endif
  end
  assign res_ttl_in = lb & ~stuck;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int exp_count(input int c);
    if (stuck[c]) return 0;
    if (rate_mode && c == 0) return rate;
    return int'(LOOP_CNT);
  endfunction

  function automatic void model(input logic [7:0] m, output logic [7:0] ea,
                                output logic [7:0] ef, output logic [7:0] el);
    ea = '0; ef = '0; el = '0;
    for (int c = 0; c < 8; c++) begin
      int  n;
      bit  ok;
      if (m[c]) begin
        n  = exp_count(c);
        if (n > 255) n = 255;
        ok = (n > int'(ETALON - TOL)) && (n < int'(ETALON + TOL));
`ifdef RES_TTL_CROSSTALK_CHK_EN
        if (short_mode && c == 2) ok = 1'b0;
`endif
        if (ok) ea[c] = 1'b1;
        else    ef[c] = 1'b1;
        el = 8'(n);
      end
    end
  endfunction

  task automatic run_sweep(input string name, input logic [7:0] m, input bit second,
                           output int done_cyc);
    logic [7:0] tog, ea, ef, el;
    int         cyc, nd;
    tog = '0; nd = 0; cyc = 0; done_cyc = 0;
    model(m, ea, ef, el);
    @(negedge clk_100Mz);
    chan_mask = m;
    start     = 1'b1;
    while (nd == 0 && cyc < BUDGET) begin
      @(posedge clk_100Mz); #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        chan_mask = 8'($urandom);
        chk({name, "_busy"}, 64'(busy), 64'(1));
      end
      if (second && cyc == 300) begin
        start     = 1'b1;
        chan_mask = ~m;
      end
      tog |= res_ttl_out;
      if (done) begin
        nd++;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    repeat (8) begin
      @(posedge clk_100Mz); #1;
      if (done) nd++;
    end
    chk({name, "_done_pulses"}, 64'(nd), 64'(1));
    chk({name, "_active"}, 64'(active), 64'(ea));
    chk({name, "_fail"}, 64'(fail_mask), 64'(ef));
    chk({name, "_last_cnt"}, 64'(last_cnt), 64'(el));
    chk({name, "_toggled"}, 64'(tog), 64'(m));
    chk({name, "_idle"}, 64'({busy, res_ttl_out}), 64'(0));
`ifdef RES_TTL_CROSSTALK_CHK_EN
    chk({name, "_xt"}, 64'(crosstalk_err), 64'((short_mode && m[2]) ? 8'h04 : 8'h00));
`endif
  endtask

  initial begin
    int dc;
    int w;
    int nd;

    repeat (4) @(negedge clk_100Mz);
    chk("reset_outs", 64'({res_ttl_out, active, fail_mask, busy, done, cur_ch, last_cnt}), 64'(0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk_100Mz);

    run_sweep("zero_mask", 8'h00, 1'b0, dc);
    chk("zero_mask_len", 64'(dc), 64'(2 * N_CH + 2));

    run_sweep("loop_ff", 8'hFF, 1'b1, dc);

    stuck = 8'h08;
    run_sweep("stuck3", 8'hFF, 1'b0, dc);
    stuck = 8'h00;

    run_sweep("mask05", 8'h05, 1'b0, dc);

    rate_mode = 1'b1;
    rate = 52; run_sweep("rate52", 8'h01, 1'b0, dc);
    rate = 48; run_sweep("rate48", 8'h01, 1'b0, dc);
    rate = 53; run_sweep("rate53", 8'h01, 1'b0, dc);
    rate_mode = 1'b0;

    // Abort in the gate of ch4
    @(negedge clk_100Mz);
    chan_mask = 8'hFF;
    start     = 1'b1;
    @(negedge clk_100Mz);
    start = 1'b0;
    w = 0;
    while (cur_ch != 3'd4 && w < BUDGET) begin
      @(negedge clk_100Mz);
      w++;
    end
    chk("abort_reach_ch4", 64'(cur_ch), 64'(4));
    repeat (100) @(negedge clk_100Mz);
    abort = 1'b1;
    @(posedge clk_100Mz); #1;
    chk("abort_busy_out", 64'({busy, res_ttl_out}), 64'(0));
    chk("abort_active", 64'(active), 64'(8'h0F));
    chk("abort_fail", 64'(fail_mask), 64'(0));
    @(negedge clk_100Mz);
    abort = 1'b0;
    nd = 0;
    repeat (30) begin
      @(posedge clk_100Mz); #1;
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'(0));

    // Asynchronous reset mid-sweep
    @(negedge clk_100Mz);
    chan_mask = 8'hFF;
    start     = 1'b1;
    @(negedge clk_100Mz);
    start = 1'b0;
    repeat (500) @(negedge clk_100Mz);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 64'({res_ttl_out, active, fail_mask, busy, done, cur_ch, last_cnt}), 64'(0));
    @(negedge clk_100Mz);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_100Mz);

    for (int it = 0; it < 5; it++) begin
      logic [7:0] m;
      m         = 8'($urandom);
      stuck     = 8'($urandom & $urandom & $urandom);
      rate_mode = 1'($urandom_range(0, 1));
      rate      = int'($urandom_range(44, 56));
      run_sweep("rand", m, 1'b0, dc);
    end
    stuck     = '0;
    rate_mode = 1'b0;

`ifdef RES_TTL_CROSSTALK_CHK_EN
    short_mode = 1'b1;
    run_sweep("xt_short", 8'hFF, 1'b0, dc);
    short_mode = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
